// File: rtl/ls_unit_if.sv
// Bundle of the load/store unit's issue, byte-memory and LS CDB signals.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface ls_unit_if #(
    parameter int TAG_W  = 6,
    parameter int NAME_W = 5,
    parameter int OP_W   = 4
);
    logic              LSworkEn;
    logic [31:0]       operandO;
    logic [31:0]       operandT;
    logic [31:0]       imm;
    logic [TAG_W-1:0]  wrtTag;
    logic [NAME_W-1:0] wrtName;
    logic [OP_W-1:0]   opCode;
    logic              LSreadEn;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_gnt;
    logic [7:0]        mem_rdata;

    logic              enLSwrt;
    logic [TAG_W-1:0]  LStag;
    logic [31:0]       LSdata;

    modport master (
        output LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode,
        input  LSreadEn,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata,
        input  enLSwrt, LStag, LSdata
    );

    modport slave (
        input  LSworkEn, operandO, operandT, imm, wrtTag, wrtName, opCode,
        output LSreadEn,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata,
        output enLSwrt, LStag, LSdata
    );
endinterface

// File: rtl/ls_unit.sv
// Load/store execution unit: one op at a time, byte-serial little-endian access
// over an 8-bit memory port, load results broadcast on the LS CDB.
module ls_unit #(
    parameter int                TAG_W     = 6,
    parameter int                NAME_W    = 5,
    parameter int                OP_W      = 4,
    parameter logic [TAG_W-1:0]  TAG_FREE  = '0,
    parameter logic [NAME_W-1:0] NAME_FREE = '0
) (
    input logic        clk,
    input logic        rst,
    ls_unit_if.slave   bus
);
    localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(8);

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

    // Index of the final byte of the access (size minus one).
    function automatic logic [1:0] last_idx(input logic [OP_W-1:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
            OP_LW, OP_SW:         last_idx = 2'd3;
            default:              last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] extend(input logic [OP_W-1:0] op, input logic [31:0] r);
        case (op)
            OP_LB:   extend = {{24{r[7]}}, r[7:0]};
            OP_LH:   extend = {{16{r[15]}}, r[15:0]};
            OP_LBU:  extend = {24'd0, r[7:0]};
            OP_LHU:  extend = {16'd0, r[15:0]};
            default: extend = r;
        endcase
    endfunction

    state_t            state;
    logic [1:0]        cnt;
    logic [OP_W-1:0]   op_q;
    logic [31:0]       addr_q;
    logic [31:0]       sdata_q;
    logic [31:0]       res_q;
    logic [TAG_W-1:0]  tag_q;
    logic [NAME_W-1:0] name_q;
    logic              en_q;
    logic [TAG_W-1:0]  lstag_q;
    logic [31:0]       lsdata_q;
    logic [31:0]       res_nxt;

    always_comb begin
        res_nxt = res_q;
        res_nxt[{cnt, 3'b000} +: 8] = bus.mem_rdata;
    end

    // Handshake outputs are gated by rst so nothing leaks out during a reset cycle.
    assign bus.LSreadEn  = (state == IDLE) && !rst;
    assign bus.mem_req   = (state == ACCESS) && !rst;
    assign bus.mem_we    = (state == ACCESS) && is_store(op_q);
    assign bus.mem_addr  = addr_q + {30'd0, cnt};
    assign bus.mem_wdata = sdata_q[{cnt, 3'b000} +: 8];
    assign bus.enLSwrt   = en_q;
    assign bus.LStag     = lstag_q;
    assign bus.LSdata    = lsdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            en_q     <= 1'b0;
            lstag_q  <= TAG_FREE;
            lsdata_q <= 32'd0;
        end else begin
            en_q     <= 1'b0;
            lstag_q  <= TAG_FREE;
            lsdata_q <= 32'd0;
            case (state)
                IDLE: begin
                    if (bus.LSworkEn && bus.opCode != OP_NOP) begin
                        op_q    <= bus.opCode;
                        addr_q  <= bus.operandO + bus.imm;
                        sdata_q <= bus.operandT;
                        tag_q   <= bus.wrtTag;
                        name_q  <= bus.wrtName;
                        cnt     <= 2'd0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_gnt) begin
                        if (is_store(op_q)) begin
                            cnt <= cnt + 2'd1;
                            if (cnt == last_idx(op_q)) state <= DONE;
                        end else begin
                            state <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    res_q <= res_nxt;
                    cnt   <= cnt + 2'd1;
                    if (cnt == last_idx(op_q)) begin
                        state <= DONE;
                        // Broadcast registers load on entry so they are valid exactly in DONE.
                        if (name_q != NAME_FREE) begin
                            en_q     <= 1'b1;
                            lstag_q  <= tag_q;
                            lsdata_q <= extend(op_q, res_nxt);
                        end
                    end else begin
                        state <= ACCESS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ls_unit.sv
// Directed self-checking bench for ls_unit with a byte-wide memory model
// that can stall grants for a programmable number of cycles.
module tb_ls_unit;
    localparam int TAG_W  = 6;
    localparam int NAME_W = 5;
    localparam int OP_W   = 4;
    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4;
    localparam logic [3:0] SH = 4'd7, SW = 4'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ls_unit_if #(.TAG_W(TAG_W), .NAME_W(NAME_W), .OP_W(OP_W)) ifc ();

    ls_unit #(.TAG_W(TAG_W), .NAME_W(NAME_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    logic [31:0] rd_addr [$];
    int          stall_n  = 0;
    int          wait_cnt = 0;
    logic [31:0] held_addr;
    logic        held_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: decides grant mid-cycle; read data appears before the RDWAIT edge.
    always @(negedge clk) begin
        if (ifc.mem_req) begin
            if (wait_cnt > 0) begin
                check("hold_addr", ifc.mem_addr, held_addr);
                check("hold_we", 32'(ifc.mem_we), 32'(held_we));
            end else begin
                held_addr = ifc.mem_addr;
                held_we   = ifc.mem_we;
            end
            if (wait_cnt < stall_n) begin
                ifc.mem_gnt = 1'b0;
                wait_cnt++;
            end else begin
                ifc.mem_gnt = 1'b1;
                wait_cnt    = 0;
                if (ifc.mem_we) begin
                    mem[ifc.mem_addr] = ifc.mem_wdata;
                    wr_addr.push_back(ifc.mem_addr);
                    wr_data.push_back(ifc.mem_wdata);
                end else begin
                    ifc.mem_rdata = mem.exists(ifc.mem_addr) ? mem[ifc.mem_addr] : 8'h00;
                    rd_addr.push_back(ifc.mem_addr);
                end
            end
        end else begin
            ifc.mem_gnt = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Issue one op and follow it until the unit is idle again.
    task automatic run(input logic [3:0] op, input logic [31:0] o, input logic [31:0] t,
                       input logic [31:0] im, input logic [5:0] tag, input logic [4:0] name,
                       input bit poke, output int bc_n, output int bc_cyc,
                       output logic [31:0] bc_data, output logic [5:0] bc_tag,
                       output int done_cyc);
        @(negedge clk);
        check("issue_ready", 32'(ifc.LSreadEn), 32'd1);
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        ifc.opCode   = op;
        ifc.operandO = o;
        ifc.operandT = t;
        ifc.imm      = im;
        ifc.wrtTag   = tag;
        ifc.wrtName  = name;
        ifc.LSworkEn = 1'b1;
        bc_n = 0; bc_cyc = -1; bc_data = 32'd0; bc_tag = 6'd0; done_cyc = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (ifc.enLSwrt) begin
                bc_n++;
                bc_cyc  = k;
                bc_data = ifc.LSdata;
                bc_tag  = ifc.LStag;
            end
            if (ifc.LSreadEn) begin
                ifc.LSworkEn = 1'b0;
                done_cyc = k;
                break;
            end
            if (poke && (k % 2 == 1)) begin
                ifc.LSworkEn = 1'b1;
                ifc.opCode   = SW;
                ifc.operandO = 32'h0000_0500;
                ifc.operandT = 32'h5555_5555;
                ifc.imm      = 32'd0;
            end else begin
                ifc.LSworkEn = 1'b0;
            end
        end
        ifc.LSworkEn = 1'b0;
    endtask

    int          bn, bc, dc, ev_bc, ev_req;
    logic [31:0] bd;
    logic [5:0]  bt;

    initial begin
        ifc.LSworkEn = 1'b0;
        ifc.operandO = 32'd0;
        ifc.operandT = 32'd0;
        ifc.imm      = 32'd0;
        ifc.wrtTag   = 6'd0;
        ifc.wrtName  = 5'd0;
        ifc.opCode   = NOP;
        mem[32'h104] = 8'h11; mem[32'h105] = 8'h22; mem[32'h106] = 8'h33; mem[32'h107] = 8'h44;
        mem[32'h200] = 8'h80;
        mem[32'h300] = 8'hFF; mem[32'h301] = 8'h7F;

        repeat (3) @(negedge clk);
        check("rst_readen", 32'(ifc.LSreadEn), 32'd0);
        check("rst_req", 32'(ifc.mem_req), 32'd0);
        check("rst_en", 32'(ifc.enLSwrt), 32'd0);
        check("rst_tag", 32'(ifc.LStag), 32'd0);
        check("rst_data", ifc.LSdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_readen", 32'(ifc.LSreadEn), 32'd1);

        // LW across four bytes
        run(LW, 32'h100, 32'd0, 32'd4, 6'd5, 5'd3, 1'b0, bn, bc, bd, bt, dc);
        check("lw_bc_n", 32'(bn), 32'd1);
        check("lw_bc_cyc", 32'(bc), 32'd9);
        check("lw_data", bd, 32'h4433_2211);
        check("lw_tag", 32'(bt), 32'd5);
        check("lw_done", 32'(dc), 32'd10);
        check("lw_nreads", 32'(rd_addr.size()), 32'd4);
        check("lw_rd0", (rd_addr.size() > 0) ? rd_addr[0] : 32'hX, 32'h104);
        check("lw_rd3", (rd_addr.size() > 3) ? rd_addr[3] : 32'hX, 32'h107);

        // Byte/half extension
        run(LB, 32'h1F0, 32'd0, 32'h10, 6'd1, 5'd1, 1'b0, bn, bc, bd, bt, dc);
        check("lb_data", bd, 32'hFFFF_FF80);
        check("lb_bc_cyc", 32'(bc), 32'd3);
        check("lb_done", 32'(dc), 32'd4);
        run(LBU, 32'h200, 32'd0, 32'd0, 6'd2, 5'd1, 1'b0, bn, bc, bd, bt, dc);
        check("lbu_data", bd, 32'h0000_0080);
        run(LH, 32'h310, 32'd0, 32'hFFFF_FFF0, 6'd3, 5'd2, 1'b0, bn, bc, bd, bt, dc);
        check("lh_data", bd, 32'h0000_7FFF);
        check("lh_bc_cyc", 32'(bc), 32'd5);

        // SH wrapping past the top of the address space
        run(SH, 32'hFFFF_FFF0, 32'hABCD_1234, 32'hF, 6'd4, 5'd4, 1'b0, bn, bc, bd, bt, dc);
        check("sh_bc_n", 32'(bn), 32'd0);
        check("sh_done", 32'(dc), 32'd4);
        check("sh_nwr", 32'(wr_addr.size()), 32'd2);
        check("sh_a0", (wr_addr.size() > 0) ? wr_addr[0] : 32'hX, 32'hFFFF_FFFF);
        check("sh_d0", (wr_data.size() > 0) ? 32'(wr_data[0]) : 32'hX, 32'h34);
        check("sh_a1", (wr_addr.size() > 1) ? wr_addr[1] : 32'hX, 32'h0000_0000);
        check("sh_d1", (wr_data.size() > 1) ? 32'(wr_data[1]) : 32'hX, 32'h12);

        // SW then read back
        run(SW, 32'h400, 32'hDEAD_BEEF, 32'd0, 6'd6, 5'd6, 1'b0, bn, bc, bd, bt, dc);
        check("sw_done", 32'(dc), 32'd6);
        check("sw_d3", (wr_data.size() > 3) ? 32'(wr_data[3]) : 32'hX, 32'hDE);
        run(LW, 32'h3FE, 32'd0, 32'd2, 6'd7, 5'd7, 1'b0, bn, bc, bd, bt, dc);
        check("sw_readback", bd, 32'hDEAD_BEEF);

        // Grant stalls of three cycles per byte, with issue pokes while busy
        stall_n = 3;
        run(LW, 32'h100, 32'd0, 32'd4, 6'd9, 5'd4, 1'b1, bn, bc, bd, bt, dc);
        stall_n = 0;
        check("stall_bc_n", 32'(bn), 32'd1);
        check("stall_bc_cyc", 32'(bc), 32'd21);
        check("stall_data", bd, 32'h4433_2211);
        check("stall_tag", 32'(bt), 32'd9);
        check("stall_done", 32'(dc), 32'd22);
        check("stall_nreads", 32'(rd_addr.size()), 32'd4);
        check("stall_nwr", 32'(wr_addr.size()), 32'd0);

        // Reset while waiting for the first read byte
        @(negedge clk);
        rd_addr.delete();
        ifc.opCode = LW; ifc.operandO = 32'h100; ifc.imm = 32'd4;
        ifc.wrtTag = 6'd12; ifc.wrtName = 5'd3; ifc.LSworkEn = 1'b1;
        @(negedge clk);
        ifc.LSworkEn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_readen_gated", 32'(ifc.LSreadEn), 32'd0);
        check("mrst_req_gated", 32'(ifc.mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_idle", 32'(ifc.LSreadEn), 32'd1);
        check("mrst_req", 32'(ifc.mem_req), 32'd0);
        ev_bc = 0; ev_req = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ifc.enLSwrt) ev_bc++;
            if (ifc.mem_req) ev_req++;
        end
        check("mrst_no_bcast", 32'(ev_bc), 32'd0);
        check("mrst_no_req", 32'(ev_req), 32'd0);
        check("mrst_nreads", 32'(rd_addr.size()), 32'd1);

        // Load to NAME_FREE and a NOP issue
        run(LW, 32'h100, 32'd0, 32'd4, 6'd8, 5'd0, 1'b0, bn, bc, bd, bt, dc);
        check("free_bc_n", 32'(bn), 32'd0);
        check("free_done", 32'(dc), 32'd10);
        run(NOP, 32'h100, 32'd0, 32'd4, 6'd8, 5'd2, 1'b0, bn, bc, bd, bt, dc);
        check("nop_done", 32'(dc), 32'd1);
        check("nop_bc_n", 32'(bn), 32'd0);
        repeat (3) @(negedge clk);
        check("nop_readen", 32'(ifc.LSreadEn), 32'd1);
        check("nop_nreads", 32'(rd_addr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
